// File: rtl/genius_input_conditioner.sv
// Input conditioner for the genius controller: per-input sync, debounce and
// edge detect, then press arbitration into single-cycle press/chord events.
module genius_input_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int CODE_W          = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               start_raw,
    input  logic               enable,
    output logic [NUM_BTN-1:0] btn_stable,
    output logic               start_pulse,
    output logic               press_valid,
    output logic [CODE_W-1:0]  press_code,
    output logic               press_multi,
    output logic               busy
);

    localparam int NIN = NUM_BTN + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    logic [NIN-1:0]     raw;
    logic [NIN-1:0]     sync1_q;
    logic [NIN-1:0]     sync2_q;
    logic [NIN-1:0]     stable_q;
    logic [NIN-1:0]     stable_d;
    logic [NIN-1:0]     stable_dly_q;
    logic [NIN-1:0]     rise;
    logic [CNT_W-1:0]   cnt_q [NIN];
    logic [CNT_W-1:0]   cnt_d [NIN];

    logic [NUM_BTN-1:0] btn_st;
    logic [NUM_BTN-1:0] btn_rise;
    logic               rise_many;
    logic               rise_other;
    logic [CODE_W-1:0]  rise_idx;

    state_t             state_q;
    state_t             state_d;
    logic               valid_q;
    logic               valid_d;
    logic               multi_q;
    logic               multi_d;
    logic               start_q;
    logic               start_d;
    logic [CODE_W-1:0]  code_q;
    logic [CODE_W-1:0]  code_d;

    assign raw = {start_raw, btn_raw};

    // Counter only advances while sync2 disagrees; agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise       = stable_q & ~stable_dly_q;
    assign btn_st     = stable_q[NUM_BTN-1:0];
    assign btn_rise   = rise[NUM_BTN-1:0];
    assign rise_many  = (btn_rise & (btn_rise - NUM_BTN'(1))) != '0;
    assign rise_other = (btn_st & ~btn_rise) != '0;

    always_comb begin
        rise_idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_rise[i]) begin
                rise_idx = CODE_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        multi_d = 1'b0;
        code_d  = code_q;
        start_d = rise[NUM_BTN];
        unique case (state_q)
            IDLE: begin
                if (btn_rise != '0) begin
                    state_d = HELD;
                    if (rise_many || rise_other) begin
                        multi_d = 1'b1;
                    end else if (enable) begin
                        valid_d = 1'b1;
                        code_d  = rise_idx;
                    end
                end
            end
            HELD: begin
                if (btn_rise != '0) begin
                    multi_d = 1'b1;
                end
                if (btn_st == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            start_q <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            start_q <= start_d;
            code_q  <= code_d;
        end
    end

    assign btn_stable  = btn_st;
    assign busy        = |btn_st;
    assign start_pulse = start_q;
    assign press_valid = valid_q;
    assign press_multi = multi_q;
    assign press_code  = code_q;

endmodule

// File: tb/tb_genius_input_conditioner.sv
// Scoreboard bench for genius_input_conditioner: expected events are queued
// when stimulus is applied and matched against pulses as they appear.
module tb_genius_input_conditioner;

    logic       clock;
    logic       reset;
    logic [2:0] btn_raw;
    logic       start_raw;
    logic       enable;
    logic [2:0] btn_stable;
    logic       start_pulse;
    logic       press_valid;
    logic [1:0] press_code;
    logic       press_multi;
    logic       busy;

    typedef struct {
        int       cyc;
        bit       multi;
        logic [1:0] code;
    } ev_t;

    ev_t q_press[$];
    int  q_start[$];
    int  cyc;
    int  total;
    int  bad;

    genius_input_conditioner dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .start_raw  (start_raw),
        .enable     (enable),
        .btn_stable (btn_stable),
        .start_pulse(start_pulse),
        .press_valid(press_valid),
        .press_code (press_code),
        .press_multi(press_multi),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc++;

    // Event monitor: every observed pulse must match the head of its queue.
    always @(negedge clock) begin
        if (press_valid || press_multi) begin
            ev_t e;
            total++;
            if (press_valid && press_multi) begin
                bad++;
                $display("FAIL both_pulses cyc=%0d valid=1 multi=1 required one only", cyc);
            end else if (q_press.size() == 0) begin
                bad++;
                $display("FAIL unexpected_press cyc=%0d valid=%0b multi=%0b code=%0d required none",
                         cyc, press_valid, press_multi, press_code);
            end else begin
                e = q_press.pop_front();
                if (e.cyc != cyc || e.multi !== press_multi ||
                    (!e.multi && press_code !== e.code)) begin
                    bad++;
                    $display("FAIL press_event got cyc=%0d multi=%0b code=%0d required cyc=%0d multi=%0b code=%0d",
                             cyc, press_multi, press_code, e.cyc, e.multi, e.code);
                end
            end
        end
        if (start_pulse) begin
            total++;
            if (q_start.size() == 0) begin
                bad++;
                $display("FAIL unexpected_start cyc=%0d required none", cyc);
            end else begin
                int ec;
                ec = q_start.pop_front();
                if (ec != cyc) begin
                    bad++;
                    $display("FAIL start_event got cyc=%0d required cyc=%0d", cyc, ec);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_press(input int dly, input bit multi, input logic [1:0] code);
        ev_t e;
        e.cyc   = cyc + dly;
        e.multi = multi;
        e.code  = code;
        q_press.push_back(e);
    endtask

    task automatic test_reset;
        reset = 1'b1; btn_raw = '0; start_raw = 1'b0; enable = 1'b1;
        tick(3);
        total += 6;
        if (btn_stable !== 3'b000) begin bad++; $display("FAIL rst_btn_stable got %b required 000", btn_stable); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b required 0", busy); end
        if (press_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b required 0", press_valid); end
        if (press_multi !== 1'b0) begin bad++; $display("FAIL rst_multi got %b required 0", press_multi); end
        if (start_pulse !== 1'b0) begin bad++; $display("FAIL rst_start got %b required 0", start_pulse); end
        if (press_code !== 2'd0) begin bad++; $display("FAIL rst_code got %0d required 0", press_code); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single;
        btn_raw = 3'b010;
        push_press(7, 1'b0, 2'd1);
        tick(5);
        total++;
        if (btn_stable !== 3'b000) begin bad++; $display("FAIL single_early got %b required 000", btn_stable); end
        tick(1);
        total += 2;
        if (btn_stable !== 3'b010) begin bad++; $display("FAIL single_stable got %b required 010", btn_stable); end
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got %b required 1", busy); end
        tick(14);
        btn_raw = '0;
        tick(12);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_release got %b required 0", busy); end
    endtask

    task automatic test_debounce;
        btn_raw = 3'b001;
        tick(3);
        btn_raw = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            total++;
            if (btn_stable !== 3'b000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL short_glitch got stable=%b busy=%b required 000/0", btn_stable, busy);
            end
        end
        btn_raw = 3'b001;
        push_press(7, 1'b0, 2'd0);
        tick(4);
        btn_raw = '0;
        tick(2);
        total++;
        if (btn_stable !== 3'b001) begin bad++; $display("FAIL four_edge_accept got %b required 001", btn_stable); end
        tick(12);
    endtask

    task automatic test_chord;
        btn_raw = 3'b101;
        push_press(7, 1'b1, 2'd0);
        tick(10);
        btn_raw = '0;
        tick(5);
        total++;
        if (btn_stable !== 3'b101) begin bad++; $display("FAIL chord_hold got %b required 101", btn_stable); end
        tick(1);
        total++;
        if (btn_stable !== 3'b000) begin bad++; $display("FAIL chord_release got %b required 000", btn_stable); end
        tick(2);
        btn_raw = 3'b100;
        push_press(7, 1'b0, 2'd2);
        tick(10);
        btn_raw = '0;
        tick(12);
    endtask

    task automatic test_enable;
        enable  = 1'b0;
        btn_raw = 3'b010;
        tick(16);
        enable = 1'b1;
        tick(10);
        btn_raw = '0;
        tick(12);
        total++;
        if (btn_stable !== 3'b000) begin bad++; $display("FAIL enable_release got %b required 000", btn_stable); end
        btn_raw = 3'b010;
        push_press(7, 1'b0, 2'd1);
        tick(10);
        btn_raw = '0;
        tick(12);
    endtask

    task automatic test_overlap;
        btn_raw = 3'b001;
        push_press(7, 1'b0, 2'd0);
        tick(10);
        btn_raw = 3'b011;
        push_press(7, 1'b1, 2'd0);
        tick(10);
        total++;
        if (press_code !== 2'd0) begin bad++; $display("FAIL code_hold got %0d required 0", press_code); end
        btn_raw = '0;
        tick(12);
        enable    = 1'b0;
        start_raw = 1'b1;
        q_start.push_back(cyc + 7);
        tick(12);
        start_raw = 1'b0;
        enable    = 1'b1;
        tick(12);
    endtask

    task automatic test_back_to_back;
        start_raw = 1'b1;
        btn_raw   = 3'b001;
        q_start.push_back(cyc + 7);
        push_press(7, 1'b0, 2'd0);
        tick(10);
        start_raw = 1'b0;
        btn_raw   = '0;
        tick(12);
    endtask

    task automatic test_reset_mid;
        btn_raw = 3'b100;
        push_press(7, 1'b0, 2'd2);
        tick(10);
        reset = 1'b1;
        tick(1);
        total += 5;
        if (btn_stable !== 3'b000) begin bad++; $display("FAIL midrst_stable got %b required 000", btn_stable); end
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b required 0", busy); end
        if (press_code !== 2'd0) begin bad++; $display("FAIL midrst_code got %0d required 0", press_code); end
        if (press_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b required 0", press_valid); end
        if (press_multi !== 1'b0) begin bad++; $display("FAIL midrst_multi got %b required 0", press_multi); end
        reset = 1'b0;
        push_press(7, 1'b0, 2'd2);
        tick(10);
        btn_raw = '0;
        tick(12);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_debounce();
        test_chord();
        test_enable();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (q_press.size() != 0 || q_start.size() != 0) begin
            bad++;
            $display("FAIL missing_events got press=%0d start=%0d pending required 0",
                     q_press.size(), q_start.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
